// File: rtl/mdr_handshake.sv
// Memory data register with a req/ack handshake to variable-latency memory.
// Handles byte/half/full lane steering, sign/zero extension and request timeout.
`timescale 1ns/1ps
module mdr_handshake #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] INIT       = '0,
   parameter int                    TIMEOUT    = 16
) (
   input  logic                    clock,
   input  logic                    clear,
   input  logic                    enable,
   input  logic [DATA_WIDTH-1:0]   BusMuxOut,
   input  logic [ADDR_WIDTH-1:0]   mar_addr,
   input  logic                    read_start,
   input  logic                    write_start,
   input  logic [1:0]              size,
   input  logic                    sign_ext,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ack,
   output logic [DATA_WIDTH-1:0]   BusMuxIn,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(LANES);

   typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ} state_t;

   state_t                  state, state_nx;
   logic [DATA_WIDTH-1:0]   data_q, data_nx;
   logic [7:0]              cnt, cnt_nx;
   logic [1:0]              size_q, size_nx;
   logic                    sext_q, sext_nx;
   logic [OFFW-1:0]         off_q, off_nx;

   logic                    mem_req_nx, mem_we_nx, busy_nx, done_nx, error_nx;
   logic [ADDR_WIDTH-1:0]   mem_addr_nx;
   logic [DATA_WIDTH-1:0]   mem_wdata_nx;
   logic [LANES-1:0]        mem_be_nx;

   logic [OFFW-1:0]         start_off;
   logic                    aligned;
   logic [LANES-1:0]        start_be;
   logic [DATA_WIDTH-1:0]   start_wdata;
   logic [DATA_WIDTH-1:0]   rd_shift;
   logic [DATA_WIDTH-1:0]   rd_ext;

   assign start_off = mar_addr[OFFW-1:0];
   assign BusMuxIn  = data_q;

   // Decode the incoming command: alignment, lane enables and replicated write data.
   always_comb begin
      aligned     = 1'b1;
      start_be    = '1;
      start_wdata = data_q;
      case (size)
         2'b00: begin
            start_be    = LANES'(1) << start_off;
            start_wdata = {LANES{data_q[7:0]}};
         end
         2'b01: begin
            aligned     = ~start_off[0];
            start_be    = LANES'(3) << start_off;
            start_wdata = {(LANES/2){data_q[15:0]}};
         end
         default: begin
            aligned = (start_off == '0);
         end
      endcase
   end

   // Bring the addressed lanes down to bit 0 and extend them.
   always_comb begin
      rd_shift = mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   rd_ext = sext_q ? DATA_WIDTH'($signed(rd_shift[7:0]))
                                  : DATA_WIDTH'(rd_shift[7:0]);
         2'b01:   rd_ext = sext_q ? DATA_WIDTH'($signed(rd_shift[15:0]))
                                  : DATA_WIDTH'(rd_shift[15:0]);
         default: rd_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx     = state;
      data_nx      = data_q;
      cnt_nx       = cnt;
      size_nx      = size_q;
      sext_nx      = sext_q;
      off_nx       = off_q;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      mem_be_nx    = mem_be;
      busy_nx      = busy;
      error_nx     = error;
      done_nx      = 1'b0;

      case (state)
         IDLE: begin
            if (read_start || write_start) begin
               error_nx    = 1'b0;
               mem_addr_nx = mar_addr;
               size_nx     = size;
               sext_nx     = sign_ext;
               off_nx      = start_off;
               cnt_nx      = '0;
               if (!aligned) begin
                  error_nx = 1'b1;
               end else if (read_start) begin
                  mem_req_nx = 1'b1;
                  mem_we_nx  = 1'b0;
                  mem_be_nx  = start_be;
                  busy_nx    = 1'b1;
                  state_nx   = RD_REQ;
               end else begin
                  mem_req_nx   = 1'b1;
                  mem_we_nx    = 1'b1;
                  mem_be_nx    = start_be;
                  mem_wdata_nx = start_wdata;
                  busy_nx      = 1'b1;
                  state_nx     = WR_REQ;
               end
            end else if (enable) begin
               data_nx = BusMuxOut;
            end
         end

         RD_REQ, WR_REQ: begin
            if (mem_ack) begin
               if (state == RD_REQ) begin
                  data_nx = rd_ext;
               end
               mem_req_nx = 1'b0;
               mem_we_nx  = 1'b0;
               mem_be_nx  = '0;
               busy_nx    = 1'b0;
               done_nx    = 1'b1;
               cnt_nx     = '0;
               state_nx   = IDLE;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               // This edge would bring the count to TIMEOUT, so abandon the access now.
               mem_req_nx = 1'b0;
               mem_we_nx  = 1'b0;
               mem_be_nx  = '0;
               busy_nx    = 1'b0;
               error_nx   = 1'b1;
               cnt_nx     = '0;
               state_nx   = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= IDLE;
         data_q    <= INIT;
         cnt       <= '0;
         size_q    <= '0;
         sext_q    <= 1'b0;
         off_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nx;
         data_q    <= data_nx;
         cnt       <= cnt_nx;
         size_q    <= size_nx;
         sext_q    <= sext_nx;
         off_q     <= off_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         mem_be    <= mem_be_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         error     <= error_nx;
      end
   end

endmodule

// File: doc/mdr_handshake.md
Name: mdr_handshake

Overview:
- Next-generation memory data register for the CPU datapath.
- Holds a DATA_WIDTH value that is loaded from the bus or from memory.
- Unlike a single-cycle MDR, it runs a req/ack handshake with a variable-latency memory, supports byte/half/full accesses with lane steering and sign/zero extension, and aborts on timeout.
- Sits between the bus, the MAR address, and the memory interface.

Parameters:
- DATA_WIDTH, 32, register/memory data width; legal values 16, 32, 64.
- ADDR_WIDTH, 32, width of the MAR address and mem_addr.
- INIT, 0, register value after reset.
- TIMEOUT, 16, cycles with mem_req high and no ack before abort; legal range 1..255.

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- enable  input  1  load BusMuxOut into the register (IDLE only).
- BusMuxOut  input  DATA_WIDTH  bus value to load, or write data source.
- mar_addr  input  ADDR_WIDTH  access address from the MAR.
- read_start  input  1  begin a memory read.
- write_start  input  1  begin a memory write of the register contents.
- size  input  2  00 byte, 01 half, 10/11 full.
- sign_ext  input  1  on reads: 1 sign-extends a byte/half, 0 zero-extends.
- mem_req  output  1  request valid; held until ack or abort.
- mem_we  output  1  1 = write request.
- mem_addr  output  ADDR_WIDTH  captured address.
- mem_wdata  output  DATA_WIDTH  lane-replicated write data.
- mem_be  output  DATA_WIDTH/8  byte-lane enables.
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  input  1  memory completion.
- BusMuxIn  output  DATA_WIDTH  register contents to the bus.
- busy  output  1  access in flight.
- done  output  1  one-cycle pulse when an access completes successfully.
- error  output  1  sticky flag for a misaligned or timed-out access.

Behaviour:
- Reset (clear low, asynchronous):
  - register = INIT; state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error and timeout counter = 0.
  - Takes effect immediately even mid-access. Any ack arriving afterwards is ignored.
- All outputs are registered. BusMuxIn always equals the register.
- States: IDLE, RD_REQ, WR_REQ.
- IDLE accepts one command per cycle, priority read_start > write_start > enable.
  - An accepted start clears error and captures address, size, sign_ext and lane offset (addr low log2(DATA_WIDTH/8) bits).
  - enable: register <= BusMuxOut at the edge; no memory activity.
- Alignment check at accept:
  - Half requires offset[0]=0; full requires offset=0.
  - Misaligned: no request issued, error=1, register unchanged, state stays IDLE, no done.
- Aligned read:
  - At accept edge N: mem_req=1, mem_we=0, mem_be = lanes of the access; state RD_REQ.
  - First ack sampling is edge N+1, so minimum latency is 2 edges.
- Aligned write:
  - Same timing as a read, with mem_we=1.
  - mem_wdata = low byte/half/full of the register, replicated across all lanes; mem_be marks the target lanes (little-endian: byte lane = offset, half lanes = offset, offset+1).
- In RD_REQ/WR_REQ, at the edge where mem_ack=1:
  - Read: register <= selected lanes of mem_rdata, shifted to bit 0 and extended to DATA_WIDTH per sign_ext. Full access loads all bits unchanged.
  - Write: register unchanged.
  - Then mem_req=0, mem_we=0, mem_be=0, busy=0, done=1 for one cycle, state IDLE.
- Timeout:
  - The counter increments each edge in a request state with mem_ack=0.
  - When the count reaches TIMEOUT: mem_req drops, error=1, no done, register unchanged, state IDLE, counter cleared.
- Ignored inputs:
  - mem_ack in IDLE.
  - read_start, write_start and enable while busy.
- Timing invariants:
  - busy = 1 exactly while state ≠ IDLE.
  - done and the next accepted start may occur back-to-back: a start accepted in the cycle done is high is legal.
- mem_addr holds the captured address while busy and retains the last value in IDLE.

Test Plan:
- Reset then enable with BusMuxOut=0xDEADBEEF -> BusMuxIn=0xDEADBEEF after one edge; mem_req stays 0.
- Byte read, addr=0x103, sign_ext=1, mem_rdata=0x80112233, ack 3 cycles after req -> mem_be=1000, register=0xFFFFFF80, done pulses once, busy low after ack edge.
- Half read, addr=0x102, sign_ext=0, mem_rdata=0x9ABC0000 -> mem_be=1100, register=0x00009ABC. Half at addr=0x101 -> error=1, mem_req never asserted.
- Byte write, register=0x000000A5, addr=0x201 -> mem_we=1, mem_wdata=0xA5A5A5A5, mem_be=0010, register unchanged, done after ack.
- Read with no ack, TIMEOUT=16 -> mem_req drops after 16 cycles, error=1, no done, register unchanged. Next read_start clears error.
- Drive clear low mid-read, then assert ack -> mem_req immediately 0, register=INIT, ack has no effect. Simultaneous read_start+enable in IDLE -> read wins, register not loaded from bus.
